mdu_hilo: RTL and testbench

- Execute-stage multiply/divide unit that owns the HI/LO register pair.
- It consumes the HILO-related control fields the decode stage emits for MULT, MULTU, DIV, DIVU, MTHI and MTLO, and supplies HI/LO to MFHI/MFLO.
- Multi-cycle operations hold the pipeline through a stall request until HI/LO are committed.

---
 rtl/mdu_hilo.sv | 174 +++++++++++++++++
 tb/tb_mdu_hilo.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mdu_hilo.sv
// Execute-stage multiply/divide unit owning the HI/LO register pair.
// MULT/MULTU complete in one extra cycle; DIV/DIVU use a 32-step restoring divider.
module mdu_hilo #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic [2:0]  op_sel,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        pipe_stall,
  input  logic        flush,
  output logic        stall_req,
  output logic        busy,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam int CNT_W = $clog2(DIV_CYCLES);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t            state, state_nxt;
  logic [31:0]       hi, hi_nxt, lo, lo_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [31:0]       a_p1, a_nxt, b_p1, b_nxt;
  logic [31:0]       rem_p1, rem_nxt, quo_p1, quo_nxt;
  logic              sgn_p1, sgn_nxt, neg_q_p1, neg_q_nxt, neg_r_p1, neg_r_nxt;

  logic signed [63:0] a_ext, b_ext, prod;
  logic [63:0]        step_res;
  logic [31:0]        rem_s, quo_s;

  function automatic logic [31:0] mag(input logic [31:0] x, input logic sgn);
    return (sgn && x[31]) ? (~x + 32'd1) : x;
  endfunction

  function automatic logic [31:0] neg_if(input logic [31:0] x, input logic neg);
    return neg ? (~x + 32'd1) : x;
  endfunction

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // rem[31] is the carry-out of the shift, so a set bit always fits.
  function automatic logic [63:0] div_step(input logic [31:0] rem, input logic [31:0] quo,
                                           input logic [31:0] d);
    logic [31:0] sh;
    logic        fits;
    sh   = {rem[30:0], quo[31]};
    fits = rem[31] || (sh >= d);
    if (fits) return {sh - d, quo[30:0], 1'b1};
    else      return {sh, quo[30:0], 1'b0};
  endfunction

  // Low 64 bits of a 64x64 product are correct for both signed and unsigned extension.
  assign a_ext    = {{32{sgn_p1 & a_p1[31]}}, a_p1};
  assign b_ext    = {{32{sgn_p1 & b_p1[31]}}, b_p1};
  assign prod     = a_ext * b_ext;
  assign step_res = div_step(rem_p1, quo_p1, b_p1);
  assign rem_s    = step_res[63:32];
  assign quo_s    = step_res[31:0];

  always_comb begin
    state_nxt = state;
    hi_nxt    = hi;
    lo_nxt    = lo;
    cnt_nxt   = cnt;
    a_nxt     = a_p1;
    b_nxt     = b_p1;
    rem_nxt   = rem_p1;
    quo_nxt   = quo_p1;
    sgn_nxt   = sgn_p1;
    neg_q_nxt = neg_q_p1;
    neg_r_nxt = neg_r_p1;
    stall_req = 1'b0;
    case (state)
      IDLE: begin
        if (op_valid && !flush) begin
          case (op_sel)
            3'b100: hi_nxt = src_a;
            3'b101: lo_nxt = src_a;
            3'b000, 3'b001: begin
              stall_req = 1'b1;
              sgn_nxt   = ~op_sel[0];
              a_nxt     = src_a;
              b_nxt     = src_b;
              state_nxt = MUL;
            end
            3'b010, 3'b011: begin
              stall_req = 1'b1;
              sgn_nxt   = ~op_sel[0];
              a_nxt     = src_a;
              quo_nxt   = mag(src_a, ~op_sel[0]);
              b_nxt     = mag(src_b, ~op_sel[0]);
              rem_nxt   = 32'd0;
              cnt_nxt   = '0;
              neg_q_nxt = ~op_sel[0] & (src_a[31] ^ src_b[31]);
              neg_r_nxt = ~op_sel[0] & src_a[31];
              state_nxt = DIV;
            end
            default: ;
          endcase
        end
      end
      MUL: begin
        stall_req = 1'b1;
        hi_nxt    = prod[63:32];
        lo_nxt    = prod[31:0];
        state_nxt = DONE;
      end
      DIV: begin
        stall_req = 1'b1;
        rem_nxt   = rem_s;
        quo_nxt   = quo_s;
        cnt_nxt   = cnt + 1'b1;
        if (cnt == CNT_W'(DIV_CYCLES - 1)) begin
          state_nxt = DONE;
          if (b_p1 == 32'd0) begin
            hi_nxt = a_p1;
            lo_nxt = 32'hFFFF_FFFF;
          end else begin
            hi_nxt = neg_if(rem_s, neg_r_p1);
            lo_nxt = neg_if(quo_s, neg_q_p1);
          end
        end
      end
      DONE: begin
        if (!pipe_stall) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // A killed instruction must leave HI/LO untouched, even on a completion edge.
    if (flush) begin
      state_nxt = IDLE;
      hi_nxt    = hi;
      lo_nxt    = lo;
      stall_req = 1'b0;
    end
    if (!resetn) stall_req = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      hi       <= 32'd0;
      lo       <= 32'd0;
      cnt      <= '0;
      a_p1     <= 32'd0;
      b_p1     <= 32'd0;
      rem_p1   <= 32'd0;
      quo_p1   <= 32'd0;
      sgn_p1   <= 1'b0;
      neg_q_p1 <= 1'b0;
      neg_r_p1 <= 1'b0;
    end else begin
      state    <= state_nxt;
      hi       <= hi_nxt;
      lo       <= lo_nxt;
      cnt      <= cnt_nxt;
      a_p1     <= a_nxt;
      b_p1     <= b_nxt;
      rem_p1   <= rem_nxt;
      quo_p1   <= quo_nxt;
      sgn_p1   <= sgn_nxt;
      neg_q_p1 <= neg_q_nxt;
      neg_r_p1 <= neg_r_nxt;
    end
  end

  assign busy   = (state != IDLE);
  assign hi_out = hi;
  assign lo_out = lo;

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed bench for mdu_hilo: MTHI/MTLO, MULT/MULTU, DIV/DIVU with boundaries,
// flush, DONE hold under pipe_stall and asynchronous reset mid-divide.
module tb_mdu_hilo;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        op_valid = 1'b0;
  logic [2:0]  op_sel = 3'b000;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        pipe_stall = 1'b0;
  logic        flush = 1'b0;
  logic        stall_req, busy;
  logic [31:0] hi_out, lo_out;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mdu_hilo #(.DIV_CYCLES(32)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .op_valid  (op_valid),
    .op_sel    (op_sel),
    .src_a     (src_a),
    .src_b     (src_b),
    .pipe_stall(pipe_stall),
    .flush     (flush),
    .stall_req (stall_req),
    .busy      (busy),
    .hi_out    (hi_out),
    .lo_out    (lo_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue an op, count stall cycles, check HI/LO in DONE, then let EX advance.
  task automatic run_op(input string tag, input logic [2:0] sel, input logic [31:0] a,
                        input logic [31:0] b, input int exp_stalls,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int stalls;
    stalls   = 0;
    op_valid = 1'b1;
    op_sel   = sel;
    src_a    = a;
    src_b    = b;
    #1;
    while (stall_req === 1'b1 && stalls < 100) begin
      stalls++;
      @(posedge clk);
      #2;
    end
    chk({tag, " stalls"}, stalls, exp_stalls);
    chk({tag, " busy_done"}, {31'd0, busy}, 32'd1);
    chk({tag, " hi"}, hi_out, exp_hi);
    chk({tag, " lo"}, lo_out, exp_lo);
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    chk({tag, " busy_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("rst stall", {31'd0, stall_req}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst hi", hi_out, 32'd0);
    chk("rst lo", lo_out, 32'd0);
    step();
    resetn = 1'b1;
    step();

    // MTHI then MTLO
    op_valid = 1'b1; op_sel = 3'b100; src_a = 32'h1234_5678; #1;
    chk("mthi stall", {31'd0, stall_req}, 32'd0);
    step();
    chk("mthi hi", hi_out, 32'h1234_5678);
    op_sel = 3'b101; src_a = 32'hDEAD_BEEF; #1;
    chk("mtlo stall", {31'd0, stall_req}, 32'd0);
    step();
    op_valid = 1'b0;
    chk("mtlo lo", lo_out, 32'hDEAD_BEEF);
    chk("mtlo hi", hi_out, 32'h1234_5678);
    chk("mtlo busy", {31'd0, busy}, 32'd0);

    run_op("mult", 3'b000, 32'hFFFF_FFFD, 32'd7, 2, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("multu", 3'b001, 32'hFFFF_FFFD, 32'd7, 2, 32'h0000_0006, 32'hFFFF_FFEB);
    run_op("div", 3'b010, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu", 3'b011, 32'd7, 32'd2, 33, 32'd1, 32'd3);
    run_op("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000);
    run_op("divu_z", 3'b011, 32'd5, 32'd0, 33, 32'd5, 32'hFFFF_FFFF);
    run_op("div_z", 3'b010, 32'hFFFF_FFF7, 32'd0, 33, 32'hFFFF_FFF7, 32'hFFFF_FFFF);

    // Flush a divide at cycle 10 of its life
    op_valid = 1'b1; op_sel = 3'b010; src_a = 32'd100; src_b = 32'd3; #1;
    repeat (10) step();
    flush = 1'b1; #1;
    chk("flush stall", {31'd0, stall_req}, 32'd0);
    chk("flush busy_before", {31'd0, busy}, 32'd1);
    step();
    chk("flush busy_after", {31'd0, busy}, 32'd0);
    chk("flush hi", hi_out, 32'hFFFF_FFF7);
    chk("flush lo", lo_out, 32'hFFFF_FFFF);
    flush = 1'b0; op_valid = 1'b0;

    // Flushed MTHI must not write
    op_valid = 1'b1; op_sel = 3'b100; src_a = 32'hAAAA_5555; flush = 1'b1;
    step();
    chk("flush mthi hi", hi_out, 32'hFFFF_FFF7);
    flush = 1'b0; op_valid = 1'b0;

    run_op("mult45", 3'b000, 32'd4, 32'd5, 2, 32'd0, 32'd20);

    // MULT completes, then DONE is held by pipe_stall for 3 cycles
    op_valid = 1'b1; op_sel = 3'b000; src_a = 32'd6; src_b = 32'd7;
    step();
    step();
    pipe_stall = 1'b1; #1;
    chk("hold lo", lo_out, 32'd42);
    chk("hold stall", {31'd0, stall_req}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("hold busy%0d", i), {31'd0, busy}, 32'd1);
      chk($sformatf("hold stall%0d", i), {31'd0, stall_req}, 32'd0);
      chk($sformatf("hold lo%0d", i), lo_out, 32'd42);
    end
    pipe_stall = 1'b0;
    op_sel = 3'b000; src_a = 32'd3; src_b = 32'd3;
    step();
    chk("b2b busy_exit", {31'd0, busy}, 32'd0);
    run_op("b2b", 3'b000, 32'd3, 32'd3, 2, 32'd0, 32'd9);

    // Asynchronous reset in the middle of a divide
    op_valid = 1'b1; op_sel = 3'b010; src_a = 32'd100; src_b = 32'd7; #1;
    repeat (5) step();
    #2;
    resetn = 1'b0;
    #1;
    chk("arst busy", {31'd0, busy}, 32'd0);
    chk("arst stall", {31'd0, stall_req}, 32'd0);
    chk("arst hi", hi_out, 32'd0);
    chk("arst lo", lo_out, 32'd0);
    op_valid = 1'b0;
    step();
    resetn = 1'b1;
    step();
    run_op("divu_post", 3'b011, 32'd100, 32'd7, 33, 32'd2, 32'd14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
